// File: rtl/walker_color_decoder_pkg.sv
// rtl/walker_color_decoder_pkg.sv - shared field positions, colour constants and nibble expansion
package walker_color_decoder_pkg;

  localparam int R_HI = 15;
  localparam int G_HI = 11;
  localparam int B_HI = 7;
  localparam int A_HI = 3;

  localparam logic [15:0] RED   = 16'hF000;
  localparam logic [15:0] CORAL = 16'hFAAA;
  localparam logic [15:0] GREY  = 16'hAAAA;
  localparam logic [15:0] WHITE = 16'hFFFF;

  // Bit replication keeps full-scale F at 3FF and zero at 000.
  function automatic logic [9:0] expand_nibble(input logic [3:0] n);
    return {n, n, n[3:2]};
  endfunction

endpackage

// File: rtl/walker_color_decoder_if.sv
// rtl/walker_color_decoder_if.sv - colour input, VGA pixel output and status bundle
interface walker_color_decoder_if #(
  parameter int AW = 2
);

  logic [15:0] iColor;
  logic        iColor_Valid;
  logic        oColor_Ready;
  logic [15:0] iBackground;
  logic        iVGA_Request;
  logic [9:0]  oVGA_R;
  logic [9:0]  oVGA_G;
  logic [9:0]  oVGA_B;
  logic        oPixel_Valid;
  logic [AW:0] oLevel;
  logic        oUnderflow;

  modport master (
    output iColor, iColor_Valid, iBackground, iVGA_Request,
    input  oColor_Ready, oVGA_R, oVGA_G, oVGA_B, oPixel_Valid, oLevel, oUnderflow
  );

  modport slave (
    input  iColor, iColor_Valid, iBackground, iVGA_Request,
    output oColor_Ready, oVGA_R, oVGA_G, oVGA_B, oPixel_Valid, oLevel, oUnderflow
  );

endinterface

// File: rtl/walker_color_decoder_color_fifo.sv
// rtl/walker_color_decoder_color_fifo.sv - power-of-two colour word FIFO with occupancy count
module walker_color_decoder_color_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [15:0]   wdata_i,
  input  logic          pop_i,
  output logic [15:0]   rdata_o,
  output logic [AW:0]   level_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);

  // Caller guarantees push only when not full and pop only when not empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_i, pop_i})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !rst_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/walker_color_decoder.sv
// rtl/walker_color_decoder.sv - buffers 4:4:4:4 colour words and decodes one per VGA request
module walker_color_decoder
  import walker_color_decoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  walker_color_decoder_if.slave  bus
);

  logic [15:0] head;
  logic [AW:0] level;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  logic [15:0] src_d;
  logic [9:0]  r_q, r_d;
  logic [9:0]  g_q, g_d;
  logic [9:0]  b_q, b_d;
  logic        pv_q, pv_d;
  logic        uf_q, uf_d;

  assign push = bus.iColor_Valid && !full;
  assign pop  = bus.iVGA_Request && !empty;

  walker_color_decoder_color_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_i   (iCLK),
    .rst_i   (iRST),
    .push_i  (push),
    .wdata_i (bus.iColor),
    .pop_i   (pop),
    .rdata_o (head),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  // Transparent words and underflow both fall back to the background colour.
  always_comb begin
    src_d = bus.iBackground;
    if (pop && (head[A_HI -: 4] != 4'h0)) src_d = head;
    r_d  = r_q;
    g_d  = g_q;
    b_d  = b_q;
    pv_d = pv_q;
    uf_d = uf_q;
    if (bus.iVGA_Request) begin
      r_d  = expand_nibble(src_d[R_HI -: 4]);
      g_d  = expand_nibble(src_d[G_HI -: 4]);
      b_d  = expand_nibble(src_d[B_HI -: 4]);
      pv_d = pop;
      if (!pop) uf_d = 1'b1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      pv_q <= 1'b0;
      uf_q <= 1'b0;
    end else begin
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
      pv_q <= pv_d;
      uf_q <= uf_d;
    end
  end

  assign bus.oColor_Ready = !full;
  assign bus.oVGA_R       = r_q;
  assign bus.oVGA_G       = g_q;
  assign bus.oVGA_B       = b_q;
  assign bus.oPixel_Valid = pv_q;
  assign bus.oLevel       = level;
  assign bus.oUnderflow   = uf_q;

endmodule
